// File: rtl/z80_uart_bus_seq.sv
// Z80 I/O cycle to 16550 bus sequencer: timed cs/rd/wr strobes,
// WAIT stretching and read-data latch for the CPU.
module z80_uart_bus_seq #(
  parameter logic [7:0] PORT_ADDR   = 8'hEF,
  parameter int         SETUP_CYC   = 2,
  parameter int         STROBE_CYC  = 4,
  parameter int         HOLD_CYC    = 2,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       iorq_n,
  input  logic       rd_n,
  input  logic       wr_n,
  input  logic       m1_n,
  input  logic [7:0] a_lo,
  input  logic [2:0] a_hi,
  input  logic [7:0] d_cpu_in,
  output logic [7:0] d_cpu_out,
  output logic       d_cpu_oe,
  output logic       ioge,
  output logic       wait_n,
  output logic [2:0] uart_a,
  input  logic [7:0] uart_d_in,
  output logic [7:0] uart_d_out,
  output logic       uart_d_oe,
  output logic       uart_cs_n,
  output logic       uart_rd_n,
  output logic       uart_wr_n,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_DONE
  } state_t;

  localparam int MAX_AB = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
  localparam int MAX_C  = (MAX_AB > HOLD_CYC) ? MAX_AB : HOLD_CYC;
  localparam int CW     = $clog2(MAX_C + 1);

  localparam logic [CW-1:0] SETUP_LD  =
    CW'((SETUP_CYC > 0) ? SETUP_CYC - 1 : 0);
  localparam logic [CW-1:0] STROBE_LD =
    CW'((STROBE_CYC > 0) ? STROBE_CYC - 1 : 0);
  localparam logic [CW-1:0] HOLD_LD   =
    CW'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            dir_wr;

  logic [SYNC_STAGES-1:0] iorq_sy, rd_sy, wr_sy, m1_sy;

  always_ff @(posedge clk) begin
    if (reset) begin
      iorq_sy <= '1;
      rd_sy   <= '1;
      wr_sy   <= '1;
      m1_sy   <= '1;
    end else begin
      iorq_sy <= {iorq_sy[SYNC_STAGES-2:0], iorq_n};
      rd_sy   <= {rd_sy[SYNC_STAGES-2:0], rd_n};
      wr_sy   <= {wr_sy[SYNC_STAGES-2:0], wr_n};
      m1_sy   <= {m1_sy[SYNC_STAGES-2:0], m1_n};
    end
  end

  logic iorq_s, rd_s, wr_s, m1_s;
  logic port_hit, hit_s, active;

  assign iorq_s   = iorq_sy[SYNC_STAGES-1];
  assign rd_s     = rd_sy[SYNC_STAGES-1];
  assign wr_s     = wr_sy[SYNC_STAGES-1];
  assign m1_s     = m1_sy[SYNC_STAGES-1];
  assign port_hit = (a_lo == PORT_ADDR);
  assign hit_s    = !iorq_s && m1_s && port_hit && (rd_s ^ wr_s);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (hit_s) begin
          if (SETUP_CYC > 0) begin
            state_d = S_SETUP;
            cnt_d   = SETUP_LD;
          end else begin
            state_d = S_STROBE;
            cnt_d   = STROBE_LD;
          end
        end
      end
      S_SETUP: begin
        if (cnt_q == '0) begin
          state_d = S_STROBE;
          cnt_d   = STROBE_LD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_STROBE: begin
        if (cnt_q == '0) begin
          if (HOLD_CYC > 0) begin
            state_d = S_HOLD;
            cnt_d   = HOLD_LD;
          end else begin
            state_d = S_DONE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_HOLD: begin
        if (cnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DONE: begin
        if (iorq_s) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Address, direction and write data are frozen for the whole access.
  always_ff @(posedge clk) begin
    if (reset) begin
      dir_wr     <= 1'b0;
      uart_a     <= '0;
      uart_d_out <= '0;
      d_cpu_out  <= '0;
    end else begin
      if (state_q == S_IDLE && hit_s) begin
        uart_a <= a_hi;
        dir_wr <= !wr_s;
        if (!wr_s) begin
          uart_d_out <= d_cpu_in;
        end
      end
      if (state_q == S_STROBE && cnt_q == '0 && !dir_wr) begin
        d_cpu_out <= uart_d_in;
      end
    end
  end

  assign active    = (state_q == S_SETUP) || (state_q == S_STROBE) ||
                     (state_q == S_HOLD);
  assign uart_cs_n = !active;
  assign uart_rd_n = !(state_q == S_STROBE && !dir_wr);
  assign uart_wr_n = !(state_q == S_STROBE && dir_wr);
  assign uart_d_oe = active && dir_wr;
  assign d_cpu_oe  = (state_q == S_DONE) && !dir_wr && !rd_n && !iorq_n;
  // Raw IDLE term asserts WAIT before the synchronizers catch up.
  assign wait_n    = !(active || (state_q == S_IDLE && !iorq_n && m1_n &&
                                  port_hit));
  assign ioge      = port_hit;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_z80_uart_bus_seq.sv
// Directed bench for z80_uart_bus_seq: default timing instance plus a
// zero-setup/zero-hold single-strobe instance on the same Z80 bus.
module tb_z80_uart_bus_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       iorq_n, rd_n, wr_n, m1_n;
  logic [7:0] a_lo;
  logic [2:0] a_hi;
  logic [7:0] d_cpu_in;
  logic [7:0] uart_d_in;

  logic [7:0] d_cpu_out, uart_d_out;
  logic       d_cpu_oe, ioge, wait_n, uart_d_oe;
  logic [2:0] uart_a;
  logic       uart_cs_n, uart_rd_n, uart_wr_n, busy;

  logic [7:0] f_d_cpu_out, f_uart_d_out;
  logic       f_d_cpu_oe, f_ioge, f_wait_n, f_uart_d_oe;
  logic [2:0] f_uart_a;
  logic       f_cs_n, f_rd_n, f_wr_n, f_busy;

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  logic       s_cs[0:15], s_wr[0:15], s_rd[0:15], s_doe[0:15];
  logic       s_wt[0:15], s_bz[0:15], s_coe[0:15];
  logic       s_fcs[0:15], s_fwr[0:15];
  logic [2:0] s_ua[0:15];
  logic [7:0] s_udo[0:15];

  always #5 clk = ~clk;

  z80_uart_bus_seq u_dut (
    .clk        (clk),
    .reset      (reset),
    .iorq_n     (iorq_n),
    .rd_n       (rd_n),
    .wr_n       (wr_n),
    .m1_n       (m1_n),
    .a_lo       (a_lo),
    .a_hi       (a_hi),
    .d_cpu_in   (d_cpu_in),
    .d_cpu_out  (d_cpu_out),
    .d_cpu_oe   (d_cpu_oe),
    .ioge       (ioge),
    .wait_n     (wait_n),
    .uart_a     (uart_a),
    .uart_d_in  (uart_d_in),
    .uart_d_out (uart_d_out),
    .uart_d_oe  (uart_d_oe),
    .uart_cs_n  (uart_cs_n),
    .uart_rd_n  (uart_rd_n),
    .uart_wr_n  (uart_wr_n),
    .busy       (busy)
  );

  z80_uart_bus_seq #(
    .SETUP_CYC  (0),
    .STROBE_CYC (1),
    .HOLD_CYC   (0)
  ) u_fast (
    .clk        (clk),
    .reset      (reset),
    .iorq_n     (iorq_n),
    .rd_n       (rd_n),
    .wr_n       (wr_n),
    .m1_n       (m1_n),
    .a_lo       (a_lo),
    .a_hi       (a_hi),
    .d_cpu_in   (d_cpu_in),
    .d_cpu_out  (f_d_cpu_out),
    .d_cpu_oe   (f_d_cpu_oe),
    .ioge       (f_ioge),
    .wait_n     (f_wait_n),
    .uart_a     (f_uart_a),
    .uart_d_in  (uart_d_in),
    .uart_d_out (f_uart_d_out),
    .uart_d_oe  (f_uart_d_oe),
    .uart_cs_n  (f_cs_n),
    .uart_rd_n  (f_rd_n),
    .uart_wr_n  (f_wr_n),
    .busy       (f_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sample index k holds outputs 1 time unit after the k-th edge
  // following the stimulus change.
  task automatic run(input int start, input int n);
    for (int k = start; k < start + n; k++) begin
      step();
      s_cs[k]  = uart_cs_n;
      s_wr[k]  = uart_wr_n;
      s_rd[k]  = uart_rd_n;
      s_doe[k] = uart_d_oe;
      s_wt[k]  = wait_n;
      s_bz[k]  = busy;
      s_coe[k] = d_cpu_oe;
      s_ua[k]  = uart_a;
      s_udo[k] = uart_d_out;
      s_fcs[k] = f_cs_n;
      s_fwr[k] = f_wr_n;
    end
  endtask

  task automatic bus_idle();
    iorq_n = 1'b1;
    rd_n   = 1'b1;
    wr_n   = 1'b1;
    m1_n   = 1'b1;
  endtask

  function automatic int lows(input logic v[0:15], input int n);
    int c = 0;
    for (int i = 0; i < n; i++) if (!v[i]) c++;
    return c;
  endfunction

  initial begin
    reset     = 1'b1;
    bus_idle();
    a_lo      = 8'h00;
    a_hi      = 3'd0;
    d_cpu_in  = 8'h00;
    uart_d_in = 8'h00;
    repeat (3) step();

    chk("rst_cs_n",    uart_cs_n,  1);
    chk("rst_rd_n",    uart_rd_n,  1);
    chk("rst_wr_n",    uart_wr_n,  1);
    chk("rst_d_oe",    uart_d_oe,  0);
    chk("rst_cpu_oe",  d_cpu_oe,   0);
    chk("rst_uart_a",  uart_a,     0);
    chk("rst_d_out",   uart_d_out, 0);
    chk("rst_cpu_out", d_cpu_out,  0);
    chk("rst_busy",    busy,       0);
    chk("rst_wait_n",  wait_n,     1);

    reset = 1'b0;
    repeat (2) step();

    // Write 0x5A to port 0x03EF
    a_lo = 8'hEF; a_hi = 3'd3; d_cpu_in = 8'h5A;
    iorq_n = 1'b0; wr_n = 1'b0;
    #1;
    chk("wr_ioge",       ioge,   1);
    chk("wr_wait_early", wait_n, 0);
    run(0, 12);
    chk("wr_cs_pre",      s_cs[1],  1);
    chk("wr_cs_fall",     s_cs[2],  0);
    chk("wr_cs_last",     s_cs[9],  0);
    chk("wr_cs_rise9",    s_cs[10], 1);
    chk("wr_cs_lows",     lows(s_cs, 12), 8);
    chk("wr_wr_pre",      s_wr[3],  1);
    chk("wr_wr_fall3",    s_wr[4],  0);
    chk("wr_wr_end",      s_wr[8],  1);
    chk("wr_wr_lows",     lows(s_wr, 12), 4);
    chk("wr_rd_lows",     lows(s_rd, 12), 0);
    chk("wr_uart_a",      s_ua[9],  3);
    chk("wr_d_out",       s_udo[9], 8'h5A);
    chk("wr_d_oe_strobe", s_doe[5], 1);
    chk("wr_d_oe_done",   s_doe[10], 0);
    chk("wr_wait_pre",    s_wt[1],  0);
    chk("wr_wait_hold",   s_wt[9],  0);
    chk("wr_wait_done",   s_wt[10], 1);
    chk("wr_busy_done",   s_bz[11], 1);
    chk("wr_cpu_oe",      lows(s_coe, 12), 12);
    chk("fast_cs_pre",    s_fcs[1], 1);
    chk("fast_wr_fall",   s_fwr[2], 0);
    chk("fast_wr_rise",   s_fwr[3], 1);
    chk("fast_wr_lows",   lows(s_fwr, 12), 1);
    chk("fast_cs_lows",   lows(s_fcs, 12), 1);
    bus_idle();
    repeat (3) step();
    chk("wr_idle_busy",   busy,   0);
    chk("fast_idle_busy", f_busy, 0);

    // Read port 0x05EF
    a_hi = 3'd5; uart_d_in = 8'hC3;
    iorq_n = 1'b0; rd_n = 1'b0;
    run(0, 12);
    chk("rd_rd_fall",   s_rd[4],  0);
    chk("rd_rd_lows",   lows(s_rd, 12), 4);
    chk("rd_wr_lows",   lows(s_wr, 12), 0);
    chk("rd_d_oe_lows", lows(s_doe, 12), 12);
    chk("rd_uart_a",    s_ua[6],  5);
    chk("rd_coe_hold",  s_coe[9], 0);
    chk("rd_coe_done",  s_coe[10], 1);
    chk("rd_cpu_out",   d_cpu_out, 8'hC3);
    chk("rd_cpu_oe_on", d_cpu_oe, 1);
    rd_n = 1'b1;
    #1;
    chk("rd_cpu_oe_off", d_cpu_oe, 0);
    bus_idle();
    repeat (3) step();
    chk("rd_idle_busy", busy, 0);

    // Non-matching port 0x00EE
    a_lo = 8'hEE; a_hi = 3'd0;
    iorq_n = 1'b0; wr_n = 1'b0;
    #1;
    chk("ee_ioge",   ioge,   0);
    chk("ee_wait_n", wait_n, 1);
    run(0, 8);
    chk("ee_cs_lows",   lows(s_cs, 8), 0);
    chk("ee_wt_lows",   lows(s_wt, 8), 0);
    chk("ee_wr_lows",   lows(s_wr, 8), 0);
    bus_idle();
    repeat (3) step();

    // Interrupt acknowledge at port 0xEF
    a_lo = 8'hEF;
    iorq_n = 1'b0; m1_n = 1'b0;
    #1;
    chk("ack_ioge",   ioge,   1);
    chk("ack_wait_n", wait_n, 1);
    run(0, 8);
    chk("ack_cs_lows", lows(s_cs, 8), 0);
    chk("ack_bz_idle", lows(s_bz, 8), 8);
    bus_idle();
    repeat (3) step();

    // rd_n and wr_n both low: not an access
    iorq_n = 1'b0; rd_n = 1'b0; wr_n = 1'b0;
    run(0, 8);
    chk("both_cs_lows", lows(s_cs, 8), 0);
    chk("both_bz_idle", lows(s_bz, 8), 8);
    bus_idle();
    repeat (3) step();

    // IORQ released early: access still completes, DONE exits at once
    a_hi = 3'd2; d_cpu_in = 8'h11;
    iorq_n = 1'b0; wr_n = 1'b0;
    run(0, 5);
    bus_idle();
    run(5, 7);
    chk("abt_wr_lows",  lows(s_wr, 12), 4);
    chk("abt_uart_a",   s_ua[6], 2);
    chk("abt_busy_d",   s_bz[10], 1);
    chk("abt_busy_off", s_bz[11], 0);
    repeat (3) step();

    // Reset asserted in the middle of a write strobe
    a_hi = 3'd1; d_cpu_in = 8'hA5;
    iorq_n = 1'b0; wr_n = 1'b0;
    run(0, 5);
    chk("rs_in_strobe", s_wr[4], 0);
    reset = 1'b1;
    bus_idle();
    step();
    chk("rs_cs_n", uart_cs_n, 1);
    chk("rs_wr_n", uart_wr_n, 1);
    chk("rs_d_oe", uart_d_oe, 0);
    chk("rs_busy", busy,      0);
    chk("rs_ua",   uart_a,    0);
    reset = 1'b0;
    repeat (2) step();

    a_hi = 3'd6; d_cpu_in = 8'h3C;
    iorq_n = 1'b0; wr_n = 1'b0;
    run(0, 12);
    chk("post_wr_fall",  s_wr[4],  0);
    chk("post_wr_lows",  lows(s_wr, 12), 4);
    chk("post_uart_a",   s_ua[8],  6);
    chk("post_d_out",    s_udo[8], 8'h3C);
    chk("post_cs_rise",  s_cs[10], 1);
    bus_idle();
    repeat (3) step();
    chk("post_busy", busy, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
